// File: rtl/dac_out_ctrl_pkg.sv
// Shared types for the multi-channel DAC output controller:
// config register addresses, config FSM states and MODE bit positions.
package dac_out_ctrl_pkg;

    typedef enum logic [1:0] {
        CFG_SCALE = 2'd0,
        CFG_BURST = 2'd1,
        CFG_HALT  = 2'd2,
        CFG_MODE  = 2'd3
    } cfg_addr_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } cfg_state_e;

    localparam int MODE_ARITH_BIT = 0;
    localparam int MODE_MUTE_BIT  = 1;

endpackage

// File: rtl/dac_out_ctrl_chan.sv
// One DAC channel: scale/mode/burst registers, per-sample right shifter,
// beat counter with halt pulse generation and saturating burst counter.
module dac_chan_ctrl
    import dac_out_ctrl_pkg::*;
#(
    parameter int BATCH_SAMPLES = 16,
    parameter int SAMPLE_WIDTH  = 16,
    parameter int BURST_W       = 16,
    localparam int LANE_W       = BATCH_SAMPLES * SAMPLE_WIDTH,
    localparam int SHIFT_W      = $clog2(SAMPLE_WIDTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              apply,
    input  cfg_addr_e         cfg_addr,
    input  logic [BURST_W-1:0] cfg_data,
    input  logic [LANE_W-1:0] in_batch,
    input  logic              in_valid,
    output logic [LANE_W-1:0] out_batch,
    output logic              out_valid,
    output logic              halt,
    output logic [15:0]       bursts_done
);

    logic [SHIFT_W-1:0] shift_reg, shift_next;
    logic               arith_reg;
    logic               mute_reg;
    logic [BURST_W-1:0] burst_size_reg;
    logic [BURST_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic [15:0]        bursts_done_reg, bursts_done_next;
    logic [LANE_W-1:0]  out_batch_reg, scaled;
    logic               out_valid_reg;
    logic               halt_reg;
    logic               beat, burst_end, cfg_clr;

    // Logical and arithmetic shifts are computed separately so the signed
    // shift keeps its sign context; a shift of SAMPLE_WIDTH fills completely.
    genvar gi;
    generate
        for (gi = 0; gi < BATCH_SAMPLES; gi++) begin : g_sample
            logic        [SAMPLE_WIDTH-1:0] s_u, s_lsr;
            logic signed [SAMPLE_WIDTH-1:0] s_s, s_asr;
            assign s_u   = in_batch[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            assign s_s   = in_batch[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            assign s_lsr = s_u >> shift_reg;
            assign s_asr = s_s >>> shift_reg;
            assign scaled[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] = arith_reg ? s_asr : s_lsr;
        end
    endgenerate

    always_comb begin
        beat      = in_valid && !mute_reg;
        burst_end = beat && (burst_size_reg != '0)
                    && (beat_cnt_reg == burst_size_reg - BURST_W'(1));
        cfg_clr   = apply && ((cfg_addr == CFG_BURST) || (cfg_addr == CFG_HALT));

        beat_cnt_next = beat_cnt_reg;
        if (cfg_clr || burst_end)
            beat_cnt_next = '0;
        else if (beat && (burst_size_reg != '0))
            beat_cnt_next = beat_cnt_reg + BURST_W'(1);

        bursts_done_next = bursts_done_reg;
        if (burst_end && (bursts_done_reg != 16'hFFFF))
            bursts_done_next = bursts_done_reg + 16'd1;

        shift_next = cfg_data[SHIFT_W-1:0];
        if (cfg_data[SHIFT_W-1:0] > SHIFT_W'(SAMPLE_WIDTH))
            shift_next = SHIFT_W'(SAMPLE_WIDTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg       <= '0;
            arith_reg       <= 1'b0;
            mute_reg        <= 1'b0;
            burst_size_reg  <= '0;
            beat_cnt_reg    <= '0;
            bursts_done_reg <= '0;
            out_batch_reg   <= '0;
            out_valid_reg   <= 1'b0;
            halt_reg        <= 1'b0;
        end else begin
            out_batch_reg   <= scaled;
            out_valid_reg   <= beat;
            // A burst end and a HALT apply in the same cycle merge into one pulse
            halt_reg        <= burst_end || (apply && (cfg_addr == CFG_HALT));
            beat_cnt_reg    <= beat_cnt_next;
            bursts_done_reg <= bursts_done_next;
            if (apply) begin
                case (cfg_addr)
                    CFG_SCALE: shift_reg      <= shift_next;
                    CFG_BURST: burst_size_reg <= cfg_data;
                    CFG_MODE: begin
                        arith_reg <= cfg_data[MODE_ARITH_BIT];
                        mute_reg  <= cfg_data[MODE_MUTE_BIT];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_batch   = out_batch_reg;
    assign out_valid   = out_valid_reg;
    assign halt        = halt_reg;
    assign bursts_done = bursts_done_reg;

endmodule

// File: rtl/dac_out_ctrl.sv
// Multi-channel DAC output controller: shared two-state config port that
// applies one register write per two cycles to a one-hot selected channel.
module dac_out_ctrl
    import dac_out_ctrl_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int BATCH_SAMPLES = 16,
    parameter int SAMPLE_WIDTH  = 16,
    parameter int BURST_W       = 16,
    parameter int CFG_WIDTH     = 32,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LANE_W       = BATCH_SAMPLES * SAMPLE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_rdy,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [1:0]               cfg_addr,
    input  logic [CFG_WIDTH-1:0]     cfg_data,
    input  logic [NUM_CH*LANE_W-1:0] in_batch,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH*LANE_W-1:0] out_batch,
    output logic [NUM_CH-1:0]        out_valid,
    output logic [NUM_CH-1:0]        halt,
    output logic [NUM_CH*16-1:0]     bursts_done
);

    cfg_state_e         state_reg, state_next;
    logic               rdy_reg;
    logic [CH_W-1:0]    ch_reg;
    cfg_addr_e          addr_reg;
    logic [BURST_W-1:0] data_reg;
    logic [NUM_CH-1:0]  apply_vec;
    logic               accept;
    logic               unused_cfg_bits;

    // Only the low BURST_W bits carry meaning for any register
    assign unused_cfg_bits = ^cfg_data[CFG_WIDTH-1:BURST_W];
    assign accept = cfg_valid && rdy_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept) state_next = ST_APPLY;
            ST_APPLY: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Ready is registered so it stays low through reset and rises one cycle after
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            rdy_reg   <= 1'b0;
            ch_reg    <= '0;
            addr_reg  <= CFG_SCALE;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            rdy_reg   <= (state_next == ST_IDLE);
            if (state_reg == ST_IDLE && accept) begin
                ch_reg   <= cfg_ch;
                addr_reg <= cfg_addr_e'(cfg_addr);
                data_reg <= cfg_data[BURST_W-1:0];
            end
        end
    end

    assign cfg_rdy = rdy_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign apply_vec[gi] = (state_reg == ST_APPLY) && (ch_reg == CH_W'(gi));

            dac_chan_ctrl #(
                .BATCH_SAMPLES (BATCH_SAMPLES),
                .SAMPLE_WIDTH  (SAMPLE_WIDTH),
                .BURST_W       (BURST_W)
            ) u_chan (
                .clk         (clk),
                .rst         (rst),
                .apply       (apply_vec[gi]),
                .cfg_addr    (addr_reg),
                .cfg_data    (data_reg),
                .in_batch    (in_batch[gi*LANE_W +: LANE_W]),
                .in_valid    (in_valid[gi]),
                .out_batch   (out_batch[gi*LANE_W +: LANE_W]),
                .out_valid   (out_valid[gi]),
                .halt        (halt[gi]),
                .bursts_done (bursts_done[gi*16 +: 16])
            );
        end
    endgenerate

endmodule

// File: tb/tb_dac_out_ctrl.sv
// Bench for dac_out_ctrl: directed scenarios plus random traffic, all outputs
// compared every cycle against a cycle-level behavioural model.
module tb_dac_out_ctrl;
    import dac_out_ctrl_pkg::*;

    localparam int NUM_CH = 4;
    localparam int BS     = 16;
    localparam int SW     = 16;
    localparam int LANE   = BS * SW;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cfg_valid;
    logic                   cfg_rdy;
    logic [1:0]             cfg_ch;
    logic [1:0]             cfg_addr;
    logic [31:0]            cfg_data;
    logic [NUM_CH*LANE-1:0] in_batch;
    logic [NUM_CH-1:0]      in_valid;
    logic [NUM_CH*LANE-1:0] out_batch;
    logic [NUM_CH-1:0]      out_valid;
    logic [NUM_CH-1:0]      halt;
    logic [NUM_CH*16-1:0]   bursts_done;

    always #5 clk = ~clk;

    dac_out_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_rdy     (cfg_rdy),
        .cfg_ch      (cfg_ch),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .in_batch    (in_batch),
        .in_valid    (in_valid),
        .out_batch   (out_batch),
        .out_valid   (out_valid),
        .halt        (halt),
        .bursts_done (bursts_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [LANE-1:0] got, input logic [LANE-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: channel settings, beats-into-burst, completed bursts,
    // and the write handshake (a write is applied one cycle after acceptance).
    int          m_shift [NUM_CH];
    bit          m_arith [NUM_CH];
    bit          m_mute  [NUM_CH];
    int          m_bsize [NUM_CH];
    int          m_cnt   [NUM_CH];
    int          m_bdone [NUM_CH];
    bit          m_pend, m_rdy;
    int          m_pch, m_paddr;
    logic [31:0] m_pdata;
    logic [LANE-1:0] e_ob  [NUM_CH];
    bit              e_ov  [NUM_CH];
    bit              e_halt[NUM_CH];

    function automatic logic [SW-1:0] mscale(input logic [SW-1:0] s, input int sh, input bit ar);
        int v;
        if (ar) begin
            v = int'($signed(s));
            v = v >>> sh;
        end else begin
            v = int'({16'h0, s});
            v = v >> sh;
        end
        return v[SW-1:0];
    endfunction

    task automatic model_step(input bit r, input bit cv, input int cc, input int ca,
                              input logic [31:0] cd, input logic [NUM_CH*LANE-1:0] ib,
                              input logic [NUM_CH-1:0] iv);
        bit beat, endb, app, acc;
        int raw;
        if (r) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_shift[c] = 0; m_arith[c] = 0; m_mute[c] = 0;
                m_bsize[c] = 0; m_cnt[c] = 0; m_bdone[c] = 0;
                e_ob[c] = '0; e_ov[c] = 0; e_halt[c] = 0;
            end
            m_pend = 0;
            m_rdy  = 0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                beat = iv[c] && !m_mute[c];
                for (int i = 0; i < BS; i++)
                    e_ob[c][i*SW +: SW] = mscale(ib[c*LANE + i*SW +: SW], m_shift[c], m_arith[c]);
                e_ov[c]   = beat;
                endb      = beat && (m_bsize[c] != 0) && (m_cnt[c] + 1 == m_bsize[c]);
                app       = m_pend && (m_pch == c);
                e_halt[c] = endb || (app && m_paddr == int'(CFG_HALT));
                if (endb && m_bdone[c] < 65535) m_bdone[c]++;
                if (app && (m_paddr == int'(CFG_BURST) || m_paddr == int'(CFG_HALT))) m_cnt[c] = 0;
                else if (endb) m_cnt[c] = 0;
                else if (beat && m_bsize[c] != 0) m_cnt[c]++;
                if (app) begin
                    if (m_paddr == int'(CFG_SCALE)) begin
                        raw = int'(m_pdata[4:0]);
                        m_shift[c] = (raw > SW) ? SW : raw;
                    end else if (m_paddr == int'(CFG_BURST)) begin
                        m_bsize[c] = int'(m_pdata[15:0]);
                    end else if (m_paddr == int'(CFG_MODE)) begin
                        m_arith[c] = m_pdata[0];
                        m_mute[c]  = m_pdata[1];
                    end
                end
            end
            acc    = cv && m_rdy;
            m_pend = acc;
            if (acc) begin
                m_pch = cc; m_paddr = ca; m_pdata = cd;
            end
            m_rdy = !acc;
        end
    endtask

    task automatic tick();
        bit                     r  = rst;
        bit                     cv = cfg_valid;
        int                     cc = int'(cfg_ch);
        int                     ca = int'(cfg_addr);
        logic [31:0]            cd = cfg_data;
        logic [NUM_CH*LANE-1:0] ib = in_batch;
        logic [NUM_CH-1:0]      iv = in_valid;
        @(posedge clk);
        model_step(r, cv, cc, ca, cd, ib, iv);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            check_val($sformatf("out_batch%0d", c), out_batch[c*LANE +: LANE], e_ob[c]);
            check_val($sformatf("out_valid%0d", c), LANE'(out_valid[c]), LANE'(e_ov[c]));
            check_val($sformatf("halt%0d", c), LANE'(halt[c]), LANE'(e_halt[c]));
            check_val($sformatf("bursts_done%0d", c), LANE'(bursts_done[c*16 +: 16]), LANE'(m_bdone[c][15:0]));
        end
        check_val("cfg_rdy", LANE'(cfg_rdy), LANE'(m_rdy));
    endtask

    task automatic rand_inputs();
        for (int k = 0; k < NUM_CH*LANE/32; k++)
            in_batch[k*32 +: 32] = $urandom;
    endtask

    task automatic cfg_write(input int ch, input int addr, input logic [31:0] data);
        bit was_rdy;
        bit done = 0;
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_addr  = 2'(addr);
        cfg_data  = data;
        for (int k = 0; k < 4 && !done; k++) begin
            was_rdy = m_rdy;
            tick();
            done = was_rdy;
        end
        check_val("cfg_accepted", LANE'(done), LANE'(1));
        cfg_valid = 1'b0;
    endtask

    task automatic scale_probe(input string tag, input logic [15:0] s, input logic [15:0] exp);
        rand_inputs();
        in_batch[LANE +: 16] = s;
        tick();
        check_val(tag, LANE'(out_batch[LANE +: 16]), LANE'(exp));
    endtask

    int hc;

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_data = '0;
        in_valid = '0;
        rand_inputs();
        m_pend = 0; m_rdy = 0; m_pch = 0; m_paddr = 0; m_pdata = '0;
        repeat (3) tick();
        check_val("rst_cfg_rdy", LANE'(cfg_rdy), LANE'(0));
        rst = 1'b0;
        tick();
        check_val("rdy_after_rst", LANE'(cfg_rdy), LANE'(1));

        // Passthrough with default settings
        in_batch[15:0] = 16'h8000; in_valid = 4'b0001;
        tick();
        check_val("pass_sample", LANE'(out_batch[15:0]), LANE'(16'h8000));
        check_val("pass_valid", LANE'(out_valid[0]), LANE'(1));
        check_val("pass_halt", LANE'(halt[0]), LANE'(0));
        in_valid = '0;

        // Scaling on channel 1
        cfg_write(1, int'(CFG_SCALE), 32'd4);  tick();
        scale_probe("lsr4", 16'hF000, 16'h0F00);
        cfg_write(1, int'(CFG_MODE), 32'd1);   tick();
        scale_probe("asr4", 16'hF000, 16'hFF00);
        cfg_write(1, int'(CFG_SCALE), 32'd20); tick();
        scale_probe("asr_clamp", 16'hF000, 16'hFFFF);
        cfg_write(1, int'(CFG_MODE), 32'd0);   tick();
        scale_probe("lsr_clamp", 16'hF000, 16'h0000);

        // Burst of 3 on channel 2, 7 beats then 2 more
        cfg_write(2, int'(CFG_BURST), 32'd3); tick();
        hc = 0;
        in_valid = 4'b0100;
        for (int b = 0; b < 7; b++) begin
            tick();
            hc += int'(halt[2]);
        end
        in_valid = '0; tick(); hc += int'(halt[2]);
        check_val("burst_halts", LANE'(hc), LANE'(2));
        check_val("burst_done2", LANE'(bursts_done[32 +: 16]), LANE'(2));
        in_valid = 4'b0100; tick();
        check_val("burst_cnt1_nohalt", LANE'(halt[2]), LANE'(0));
        tick();
        check_val("burst_cnt1_halt", LANE'(halt[2]), LANE'(1));
        in_valid = '0; tick();

        // HALT write applied on the same edge as the burst-end beat on channel 3
        cfg_write(3, int'(CFG_BURST), 32'd2); tick();
        hc = 0;
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_addr = 2'(CFG_HALT); cfg_data = $urandom;
        in_valid = 4'b1000;
        tick(); hc += int'(halt[3]);
        cfg_valid = 1'b0;
        tick(); hc += int'(halt[3]);
        in_valid = '0;
        tick(); hc += int'(halt[3]);
        tick(); hc += int'(halt[3]);
        check_val("collide_pulses", LANE'(hc), LANE'(1));
        check_val("collide_done", LANE'(bursts_done[48 +: 16]), LANE'(1));
        in_valid = 4'b1000; tick();
        check_val("collide_fresh1", LANE'(halt[3]), LANE'(0));
        tick();
        check_val("collide_fresh2", LANE'(halt[3]), LANE'(1));
        in_valid = '0; tick();

        // Mute channel 0 while channel 1 bursts; writes issued back to back
        cfg_write(0, int'(CFG_BURST), 32'd2);
        cfg_write(0, int'(CFG_MODE), 32'd2);
        cfg_write(1, int'(CFG_BURST), 32'd2);
        tick();
        hc = 0;
        in_valid = 4'b0011;
        for (int b = 0; b < 6; b++) begin
            tick();
            hc += int'(halt[1]);
            check_val("mute_valid", LANE'(out_valid[0]), LANE'(0));
            check_val("mute_halt", LANE'(halt[0]), LANE'(0));
        end
        check_val("iso_halts", LANE'(hc), LANE'(3));
        in_valid = '0;
        cfg_write(0, int'(CFG_MODE), 32'd0); tick();
        in_valid = 4'b0001; tick(); tick();
        in_valid = '0; tick();

        // Reset in the middle of a burst
        cfg_write(2, int'(CFG_BURST), 32'd5); tick();
        in_valid = 4'b0100;
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        in_valid = '0; tick();
        hc = 0;
        in_valid = 4'b0100;
        for (int b = 0; b < 5; b++) begin
            tick();
            hc += int'(halt[2]);
        end
        in_valid = '0;
        check_val("rst_no_halt", LANE'(hc), LANE'(0));
        check_val("rst_done2", LANE'(bursts_done[32 +: 16]), LANE'(0));
        scale_probe("rst_scale", 16'hF000, 16'hF000);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            rand_inputs();
            in_valid  = 4'($urandom);
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_ch    = 2'($urandom);
            cfg_addr  = 2'($urandom);
            if (cfg_addr == 2'(CFG_BURST))      cfg_data = $urandom_range(0, 5);
            else if (cfg_addr == 2'(CFG_SCALE)) cfg_data = $urandom_range(0, 31);
            else                                cfg_data = $urandom;
            rst = ($urandom_range(0, 249) == 0);
            tick();
        end
        rst = 1'b0; cfg_valid = 1'b0; in_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_out_ctrl.md
# dac_out_ctrl

Parametrised multi-channel DAC output controller between the per-channel sample generators and the DAC ports. It applies per-channel configuration: output scaling by right shift, burst-length limiting with halt pulse generation, and channel mute. Configuration arrives from the AXI-slave memory-map decode through a single shared write port. It generalises the single-channel scale/burst/halt control of the system top to NUM_CH independent channels, adding signed scaling, mute and a burst-completion counter.

## Interface
- NUM_CH, 4, number of DAC channels
- BATCH_SAMPLES, 16, samples per batch
- SAMPLE_WIDTH, 16, bits per sample
- BURST_W, 16, width of burst size and beat counter
- CFG_WIDTH, 32, configuration data width
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- cfg_valid  in  1  config write request
- cfg_rdy  out  1  config port ready
- cfg_ch  in  $clog2(NUM_CH)  target channel
- cfg_addr  in  2  0=SCALE, 1=BURST, 2=HALT, 3=MODE
- cfg_data  in  CFG_WIDTH  config value
- in_batch  in  NUM_CH×BATCH_SAMPLES×SAMPLE_WIDTH  input batches
- in_valid  in  NUM_CH  per-channel batch valid
- out_batch  out  NUM_CH×BATCH_SAMPLES×SAMPLE_WIDTH  scaled batches
- out_valid  out  NUM_CH  per-channel output valid
- halt  out  NUM_CH  one-cycle halt pulse to the generator
- bursts_done  out  NUM_CH×16  saturating count of completed bursts

## Operation
- Reset: all outputs 0, including cfg_rdy. cfg_rdy goes to 1 in the first cycle after rst deasserts. Per channel: scale=0, burst_size=0, mode=0 (logical shift, unmuted), beat counter=0. A pending config write is dropped.
- Config FSM (shared), states IDLE and APPLY. cfg_rdy = (state==IDLE).
  - IDLE: on cfg_valid && cfg_rdy, latch ch/addr/data and go to APPLY.
  - APPLY: update the target register, return to IDLE.
  - Maximum config rate is one write every 2 cycles.
- SCALE: shift = cfg_data[$clog2(SAMPLE_WIDTH):0]. A shift of SAMPLE_WIDTH or more clamps to SAMPLE_WIDTH.
- MODE: bit0 = arithmetic shift (sign fill); bit1 = mute. Upper bits are ignored.
- Scaling: each sample is shifted right by the channel's shift.
  - Logical mode: a clamped shift yields 0.
  - Arithmetic mode: a clamped shift yields all sign bits.
- BURST: burst_size = cfg_data[BURST_W-1:0]. The write also clears that channel's beat counter. burst_size=0 means continuous (no automatic halt).
- Beat counting: a beat is in_valid[c] && !mute[c]. With burst_size≠0:
  - Counter increments per beat.
  - On a beat with counter==burst_size-1: counter→0, halt[c] pulses the next cycle, bursts_done[c] increments (saturating at 16'hFFFF).
- HALT write (any data): halt[c] pulses and the beat counter clears.
- Mute: out_valid[c] is forced 0 and the counter is frozen; out_batch still updates.

## Timing
- Datapath latency is 1 cycle. out_batch/out_valid are registered from in_batch/in_valid at the same edge the counter updates.
- Config accepted at edge T: register written at edge T+1, effective for input sampled at edge T+2 onward.
- HALT write accepted at T: halt high during cycle T+1→T+2 only.
- Burst-end beat sampled at edge T: halt high for exactly the cycle after edge T.
- Simultaneous burst-end beat and HALT/BURST apply on the same channel: a single one-cycle halt pulse, counter ends at 0, bursts_done increments once.
- A burst_size change applied mid-burst restarts the count from 0 with the new size.
- Config applied to channel a never disturbs channel b's counter or output.
- rst asserted mid-burst: every register returns to its reset value at that edge. halt is 0 during reset.

## Structure
- dac_out_ctrl_pkg holds:
  - the cfg_addr enum (CFG_SCALE, CFG_BURST, CFG_HALT, CFG_MODE)
  - the config FSM state enum
  - the MODE bit indices
- Sub-module dac_chan_ctrl: one channel's scale/mode/burst registers, shifter, beat counter, halt and bursts_done. It is instantiated NUM_CH times in a generate loop.
- The top holds the shared config FSM and a one-hot apply decode per channel.

## Test plan
- Reset passthrough: release rst, drive ch0 sample 16'h8000 with in_valid → out_valid one cycle later, sample 16'h8000, halt=0.
- Scaling: ch1 SCALE=4, logical → 16'hF000 becomes 16'h0F00. Set MODE=1 (arithmetic) → 16'hFF00. SCALE=20 → 0 logical, 16'hFFFF arithmetic.
- Burst: ch2 BURST=3, drive 7 consecutive beats → halt pulses after beats 3 and 6, bursts_done=2, counter=1.
- Collision: ch3 BURST=2 with a HALT write applied on the same cycle as the 2nd beat → exactly one halt pulse, bursts_done=1, next burst needs 2 fresh beats.
- Mute and isolation: ch0 MODE=2 (mute) with continuous beats → out_valid[0]=0 and counter frozen. Channel 1 burst counting is unaffected. cfg_rdy toggles 1,0 under back-to-back cfg_valid.
- Reset mid-burst: ch2 BURST=5, 3 beats, assert rst → counter/scale/burst/bursts_done=0. Afterwards 5 beats produce no halt (burst_size=0).
